// File: rtl/uart_response_monitor.sv
// uart_response_monitor
// Receive side of the WiFi-module UART link. Deserialises the module's TX line
// (8N1, LSB first) and watches the byte stream for AT-command responses.
// While armed, it reports "OK\r\n", "ERROR\r\n" or the send prompt '>',
// or a timeout if none of these arrives in time.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   rx           in   serial line from the module (idle high, asynchronous)
//   arm          in   1-cycle pulse: clear matcher and timeout, start listening
//   rxByte       out  last received byte, valid while rxValid=1
//   rxValid      out  1-cycle pulse: new byte in rxByte
//   framingErr   out  1-cycle pulse: stop bit sampled low, byte discarded
//   busy         out  armed and waiting for a response token
//   respOk       out  1-cycle pulse: "OK\r\n" completed while armed
//   respErr      out  1-cycle pulse: "ERROR\r\n" completed while armed
//   respPrompt   out  1-cycle pulse: '>' received while armed
//   respTimeout  out  1-cycle pulse: armed window expired without a token
module uart_response_monitor #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       arm,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       framingErr,
    output logic       busy,
    output logic       respOk,
    output logic       respErr,
    output logic       respPrompt,
    output logic       respTimeout
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned IDX_W  = 3;

    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [IDX_W-1:0] OK_LAST  = IDX_W'(3);
    localparam logic [IDX_W-1:0] ERR_LAST = IDX_W'(6);

    localparam logic [7:0] CH_O  = 8'h4F;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_GT = 8'h3E;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Expected character at each position of "OK\r\n".
    function automatic logic [7:0] ok_char(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(0): ok_char = CH_O;
            IDX_W'(1): ok_char = CH_K;
            IDX_W'(2): ok_char = CH_CR;
            default:   ok_char = CH_LF;
        endcase
    endfunction

    // Expected character at each position of "ERROR\r\n".
    function automatic logic [7:0] err_char(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_W'(0): err_char = CH_E;
            IDX_W'(1): err_char = CH_R;
            IDX_W'(2): err_char = CH_R;
            IDX_W'(3): err_char = CH_O;
            IDX_W'(4): err_char = CH_R;
            IDX_W'(5): err_char = CH_CR;
            default:   err_char = CH_LF;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // rx synchroniser; rx_prev_q gives the previous synced value for
    // falling-edge detection. All preset to the idle level.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_e         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_valid_q, rx_valid_d;
    logic              framing_err_q, framing_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q    <= RX_IDLE;
            baud_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            baud_q        <= baud_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
        end
    end

    // Counters are cleared on every state change so each state times
    // itself from entry.
    always_comb begin
        rx_state_d    = rx_state_q;
        baud_d        = baud_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = 1'b0;
        framing_err_d = 1'b0;

        unique case (rx_state_q)
            RX_IDLE: begin
                // Edge-triggered so a held-low break cannot restart a frame.
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    baud_d     = '0;
                    bit_d      = '0;
                end
            end

            RX_START: begin
                if (baud_q == HALF_LAST) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    baud_d     = '0;
                    bit_d      = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            RX_DATA: begin
                if (baud_q == BIT_LAST) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    baud_d  = '0;
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                        bit_d      = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            RX_STOP: begin
                if (baud_q == BIT_LAST) begin
                    if (rx_sync_q) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        framing_err_d = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                    baud_d     = '0;
                    bit_d      = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                rx_state_d = RX_IDLE;
                baud_d     = '0;
                bit_d      = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response matcher and timeout
    // ------------------------------------------------------------------
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  ok_idx_q, ok_idx_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              resp_ok_q, resp_ok_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_prompt_q, resp_prompt_d;
    logic              resp_timeout_q, resp_timeout_d;
    logic              ok_done;
    logic              err_done;
    logic              prompt_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q         <= 1'b0;
            ok_idx_q       <= '0;
            err_idx_q      <= '0;
            tmo_cnt_q      <= '0;
            resp_ok_q      <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_prompt_q  <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            ok_idx_q       <= ok_idx_d;
            err_idx_q      <= err_idx_d;
            tmo_cnt_q      <= tmo_cnt_d;
            resp_ok_q      <= resp_ok_d;
            resp_err_q     <= resp_err_d;
            resp_prompt_q  <= resp_prompt_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    always_comb begin
        busy_d         = busy_q;
        ok_idx_d       = ok_idx_q;
        err_idx_d      = err_idx_q;
        tmo_cnt_d      = tmo_cnt_q;
        resp_ok_d      = 1'b0;
        resp_err_d     = 1'b0;
        resp_prompt_d  = 1'b0;
        resp_timeout_d = 1'b0;
        ok_done        = 1'b0;
        err_done       = 1'b0;
        prompt_done    = 1'b0;

        // Token progress; a mismatching byte may itself start a new attempt.
        if (busy_q && rx_valid_q) begin
            if (rx_byte_q == ok_char(ok_idx_q)) begin
                if (ok_idx_q == OK_LAST) begin
                    ok_done = 1'b1;
                end else begin
                    ok_idx_d = ok_idx_q + IDX_W'(1);
                end
            end else begin
                ok_idx_d = (rx_byte_q == CH_O) ? IDX_W'(1) : IDX_W'(0);
            end

            if (rx_byte_q == err_char(err_idx_q)) begin
                if (err_idx_q == ERR_LAST) begin
                    err_done = 1'b1;
                end else begin
                    err_idx_d = err_idx_q + IDX_W'(1);
                end
            end else begin
                err_idx_d = (rx_byte_q == CH_E) ? IDX_W'(1) : IDX_W'(0);
            end

            prompt_done = (rx_byte_q == CH_GT);
        end

        if (arm) begin
            // Arm overrides everything, including a token finishing now.
            busy_d    = 1'b1;
            ok_idx_d  = '0;
            err_idx_d = '0;
            tmo_cnt_d = '0;
        end else if (busy_q) begin
            if (ok_done || err_done || prompt_done) begin
                // Token beats a timeout landing on the same cycle.
                resp_ok_d     = ok_done;
                resp_err_d    = err_done && !ok_done;
                resp_prompt_d = prompt_done && !ok_done && !err_done;
                busy_d        = 1'b0;
                ok_idx_d      = '0;
                err_idx_d     = '0;
                tmo_cnt_d     = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
                resp_timeout_d = 1'b1;
                busy_d         = 1'b0;
                ok_idx_d       = '0;
                err_idx_d      = '0;
                tmo_cnt_d      = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
    end

    assign rxByte      = rx_byte_q;
    assign rxValid     = rx_valid_q;
    assign framingErr  = framing_err_q;
    assign busy        = busy_q;
    assign respOk      = resp_ok_q;
    assign respErr     = resp_err_q;
    assign respPrompt  = resp_prompt_q;
    assign respTimeout = resp_timeout_q;

endmodule

// File: tb/tb_uart_response_monitor.sv
// Directed bench for uart_response_monitor: a table of single frames plus
// hand-written sequences for token matching, reset and timeout windows.
module tb_uart_response_monitor;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       arm = 1'b0;
    logic [7:0] rxByte;
    logic       rxValid, framingErr, busy, respOk, respErr, respPrompt, respTimeout;

    logic       rx_to = 1'b1;
    logic       arm_to = 1'b0;
    logic [7:0] rxByte_to;
    logic       rxValid_to, framingErr_to, busy_to;
    logic       respOk_to, respErr_to, respPrompt_to, respTimeout_to;

    uart_response_monitor #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(20000)) dut (
        .clk(clk), .reset(reset), .rx(rx), .arm(arm),
        .rxByte(rxByte), .rxValid(rxValid), .framingErr(framingErr), .busy(busy),
        .respOk(respOk), .respErr(respErr), .respPrompt(respPrompt),
        .respTimeout(respTimeout)
    );

    uart_response_monitor #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(100)) dut_to (
        .clk(clk), .reset(reset), .rx(rx_to), .arm(arm_to),
        .rxByte(rxByte_to), .rxValid(rxValid_to), .framingErr(framingErr_to),
        .busy(busy_to), .respOk(respOk_to), .respErr(respErr_to),
        .respPrompt(respPrompt_to), .respTimeout(respTimeout_to)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    int cyc = 0;
    int n_valid = 0, n_ferr = 0, n_ok = 0, n_err = 0, n_prompt = 0;
    int n_tmo_main = 0, n_tmo = 0;
    int valid_cyc = 0, ok_cyc = 0, prompt_cyc = 0;
    logic busy_prev = 1'b0, busy_at_ok = 1'b0, busy_before_ok = 1'b0;
    logic [7:0] prompt_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rxValid) begin
            n_valid   <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (framingErr) n_ferr <= n_ferr + 1;
        if (respOk) begin
            n_ok           <= n_ok + 1;
            ok_cyc         <= cyc;
            busy_at_ok     <= busy;
            busy_before_ok <= busy_prev;
        end
        if (respErr) n_err <= n_err + 1;
        if (respPrompt) begin
            n_prompt    <= n_prompt + 1;
            prompt_cyc  <= cyc;
            prompt_byte <= rxByte;
        end
        if (respTimeout) n_tmo_main <= n_tmo_main + 1;
        if (respTimeout_to) n_tmo <= n_tmo + 1;
        busy_prev <= busy;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       do_arm;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_byte;
        int         exp_prompt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int v0, f0, p0, o0, e0, t0, found;
        logic [7:0] mid;

        vecs[0] = '{8'h41, 1'b1, 1'b0, 1, 0, 8'h41, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 0, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 0, 8'hFF, 0};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 1, 0, 8'hA5, 0};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 0, 1, 8'hA5, 0};
        vecs[5] = '{8'h3E, 1'b1, 1'b0, 1, 0, 8'h3E, 0};
        vecs[6] = '{8'h3E, 1'b1, 1'b1, 1, 0, 8'h3E, 1};
        vecs[7] = '{8'h81, 1'b1, 1'b0, 1, 0, 8'h81, 0};

        // Reset state
        tick(3);
        check("reset_rxByte", int'(rxByte), 0);
        check("reset_flags", int'({rxValid, framingErr, busy, respOk, respErr,
                                     respPrompt, respTimeout}), 0);
        reset = 1'b1;
        tick(4);

        // Table of single frames (includes framing error vector)
        for (int i = 0; i < 8; i++) begin
            v0 = n_valid; f0 = n_ferr; p0 = n_prompt;
            if (vecs[i].do_arm) pulse_arm();
            send_byte(vecs[i].data, vecs[i].stop_ok);
            check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_byte", i), int'(rxByte), int'(vecs[i].exp_byte));
            check($sformatf("vec%0d_prompt", i), n_prompt - p0, vecs[i].exp_prompt);
        end

        // Reset mid-byte, then a clean 0x41
        mid = 8'h41;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = mid[i];
            tick(CPB);
        end
        reset = 1'b0;
        #1;
        check("midreset_rxByte_async", int'(rxByte), 0);
        rx = 1'b1;
        tick(3);
        check("midreset_flags", int'({rxValid, framingErr, busy, respOk, respErr,
                                       respPrompt, respTimeout}), 0);
        reset = 1'b1;
        tick(4);
        v0 = n_valid; f0 = n_ferr;
        send_byte(8'h41, 1'b1);
        check("after_reset_valid", n_valid - v0, 1);
        check("after_reset_byte", int'(rxByte), 8'h41);
        check("after_reset_ferr", n_ferr - f0, 0);

        // OK with noise before it
        v0 = n_valid; o0 = n_ok; e0 = n_err; p0 = n_prompt;
        pulse_arm();
        check("ok_busy_armed", int'(busy), 1);
        send_str("AT\r\r\nOK\r\n");
        check("ok_valid_count", n_valid - v0, 9);
        check("ok_pulses", n_ok - o0, 1);
        check("ok_latency", ok_cyc - valid_cyc, 1);
        check("ok_busy_low_with_pulse", int'(busy_at_ok), 0);
        check("ok_busy_high_before", int'(busy_before_ok), 1);
        check("ok_other_resp", (n_err - e0) + (n_prompt - p0), 0);

        // ERROR via restart on 'E'
        o0 = n_ok; e0 = n_err;
        pulse_arm();
        send_str("ERRERROR\r\n");
        check("err_pulses", n_err - e0, 1);
        check("err_no_ok", n_ok - o0, 0);
        check("err_busy_cleared", int'(busy), 0);

        // Prompt, then an unarmed OK
        p0 = n_prompt;
        pulse_arm();
        send_byte(8'h3E, 1'b1);
        check("prompt_pulses", n_prompt - p0, 1);
        check("prompt_latency", prompt_cyc - valid_cyc, 1);
        check("prompt_byte", int'(prompt_byte), 8'h3E);
        v0 = n_valid; o0 = n_ok; e0 = n_err; p0 = n_prompt;
        send_str("OK\r\n");
        check("unarmed_valid", n_valid - v0, 4);
        check("unarmed_no_resp", (n_ok - o0) + (n_err - e0) + (n_prompt - p0), 0);

        // Short glitch on rx must not start a frame
        v0 = n_valid; f0 = n_ferr;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch_no_valid", n_valid - v0, 0);
        check("glitch_no_ferr", n_ferr - f0, 0);

        // Timeout window of 100 cycles, then re-arm half way through
        t0 = n_tmo;
        arm_to = 1'b1;
        tick(1);
        arm_to = 1'b0;
        check("tmo_busy_armed", int'(busy_to), 1);
        found = -1;
        for (int k = 1; k <= 200 && found < 0; k++) begin
            tick(1);
            if (respTimeout_to) found = k;
        end
        check("tmo_latency", found, 100);
        check("tmo_busy_cleared", int'(busy_to), 0);

        arm_to = 1'b1;
        tick(1);
        arm_to = 1'b0;
        tick(49);
        arm_to = 1'b1;
        tick(1);
        arm_to = 1'b0;
        check("rearm_busy", int'(busy_to), 1);
        check("rearm_no_early_tmo", n_tmo - t0, 1);
        found = -1;
        for (int k = 1; k <= 200 && found < 0; k++) begin
            tick(1);
            if (respTimeout_to) found = k;
        end
        check("rearm_tmo_latency", found, 100);
        tick(2);
        check("tmo_total_pulses", n_tmo - t0, 2);
        check("main_never_timed_out", n_tmo_main, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
